// File: rtl/wb_bus_lock_arbiter.sv
// wb_bus_lock_arbiter: round-robin Wishbone arbiter that holds the grant for a whole cyc, with a stall watchdog
module wb_bus_lock_arbiter #(
    parameter int MASTERS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [MASTERS*32-1:0]   m_adr_i,
    input  logic [MASTERS*32-1:0]   m_dat_i,
    input  logic [MASTERS*4-1:0]    m_sel_i,
    input  logic [MASTERS*2-1:0]    m_bte_i,
    input  logic [MASTERS*3-1:0]    m_cti_i,
    input  logic [MASTERS-1:0]      m_we_i,
    input  logic [MASTERS-1:0]      m_cyc_i,
    input  logic [MASTERS-1:0]      m_stb_i,
    output logic [31:0]             m_dat_o,
    output logic [MASTERS-1:0]      m_ack_o,
    output logic [MASTERS-1:0]      m_err_o,
    output logic [MASTERS-1:0]      m_rty_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    output logic [3:0]              s_sel_o,
    output logic [1:0]              s_bte_o,
    output logic [2:0]              s_cti_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic [31:0]             s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    output logic [MASTERS-1:0]      grant_o
);
    localparam int IW = $clog2(MASTERS);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      last_grant, sel;
    logic [MASTERS-1:0] sel_oh;
    logic [15:0]        wd_cnt, wd_cnt_n;
    logic               cyc_g, stb_g, resp, wd_fire;

    // Descending scan so the nearest requester above last_grant wins
    always_comb begin
        sel = last_grant;
        for (int i = MASTERS; i >= 1; i--)
            if (m_cyc_i[(int'(last_grant) + i) % MASTERS]) sel = IW'((int'(last_grant) + i) % MASTERS);
        sel_oh = '0;
        sel_oh[sel] = 1'b1;
    end

    // grant_o is zero outside GRANTED, so it alone gates the datapath and responses
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_bte_o = '0;
        s_cti_o = '0;
        s_we_o  = 1'b0;
        cyc_g   = 1'b0;
        stb_g   = 1'b0;
        for (int k = 0; k < MASTERS; k++)
            if (grant_o[k]) begin
                s_adr_o = m_adr_i[32*k +: 32];
                s_dat_o = m_dat_i[32*k +: 32];
                s_sel_o = m_sel_i[4*k +: 4];
                s_bte_o = m_bte_i[2*k +: 2];
                s_cti_o = m_cti_i[3*k +: 3];
                s_we_o  = m_we_i[k];
                cyc_g   = m_cyc_i[k];
                stb_g   = m_stb_i[k];
            end
        resp     = s_ack_i | s_err_i | s_rty_i;
        wd_fire  = stb_g && !resp && wd_cnt == 16'(TIMEOUT - 1);
        wd_cnt_n = (stb_g && !resp && !wd_fire) ? wd_cnt + 16'd1 : '0;
        s_cyc_o  = cyc_g;
        s_stb_o  = stb_g & ~wd_fire;
        m_ack_o  = grant_o & {MASTERS{s_ack_i}};
        m_err_o  = grant_o & {MASTERS{s_err_i | wd_fire}};
        m_rty_o  = grant_o & {MASTERS{s_rty_i}};
        state_n  = (state == IDLE) ? (|m_cyc_i ? GRANTED : IDLE) : (cyc_g ? GRANTED : IDLE);
    end

    assign m_dat_o = s_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant_o    <= '0;
            last_grant <= IW'(MASTERS - 1);
            wd_cnt     <= '0;
        end else begin
            state  <= state_n;
            wd_cnt <= wd_cnt_n;
            if (state == IDLE && |m_cyc_i) begin
                grant_o    <= sel_oh;
                last_grant <= sel;
            end else if (state == GRANTED && !cyc_g) begin
                grant_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_wb_bus_lock_arbiter.sv
// tb_wb_bus_lock_arbiter: directed self-checking bench for the locking round-robin Wishbone arbiter
module tb_wb_bus_lock_arbiter;
    localparam int M = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [M*32-1:0] m_adr_i = '0, m_dat_i = '0;
    logic [M*4-1:0]  m_sel_i = '0;
    logic [M*2-1:0]  m_bte_i = '0;
    logic [M*3-1:0]  m_cti_i = '0;
    logic [M-1:0]    m_we_i = '0, m_cyc_i = '0, m_stb_i = '0;
    logic [31:0]     m_dat_o;
    logic [M-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [3:0]      s_sel_o;
    logic [1:0]      s_bte_o;
    logic [2:0]      s_cti_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [31:0]     s_dat_i = '0;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;

    int checks = 0;
    int errors = 0;

    wb_bus_lock_arbiter #(.MASTERS(M), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_bte_i(m_bte_i),
        .m_cti_i(m_cti_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_bte_o(s_bte_o),
        .s_cti_o(s_cti_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc_i[k] = cyc;
        m_stb_i[k] = stb;
        m_we_i[k]  = we;
        m_adr_i[32*k +: 32] = adr;
        m_dat_i[32*k +: 32] = dat;
        m_sel_i[4*k +: 4]   = 4'hF;
    endtask

    task automatic do_reset();
        #2 rst_ni = 1'b0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_grant", grant_o, 4'b0000);
        chk("rst_cyc", {s_cyc_o, s_stb_o}, 2'b00);
        chk("rst_resp", {m_ack_o, m_err_o, m_rty_o}, 12'h000);
        step();
        #3 rst_ni = 1'b1;
        step();

        // Single read from master 1
        set_m(1, 1, 1, 0, 32'h100, 32'h0);
        #1 chk("t1_pre_grant", grant_o, 4'b0000);
        chk("t1_pre_cyc", s_cyc_o, 1'b0);
        step();
        chk("t1_grant", grant_o, 4'b0010);
        chk("t1_adr", s_adr_o, 32'h100);
        chk("t1_cycstb", {s_cyc_o, s_stb_o, s_we_o}, 3'b110);
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEADBEEF;
        #1 chk("t1_ack", m_ack_o, 4'b0010);
        chk("t1_dat", m_dat_o, 32'hDEADBEEF);
        step();
        s_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        #1 chk("t1_cyc_drop", s_cyc_o, 1'b0);
        chk("t1_grant_hold", grant_o, 4'b0010);
        step();
        chk("t1_release", grant_o, 4'b0000);

        // Round robin across masters 0, 2, 3
        do_reset();
        set_m(0, 1, 1, 0, 32'h10, 0);
        set_m(2, 1, 1, 0, 32'h20, 0);
        set_m(3, 1, 1, 0, 32'h30, 0);
        step();
        chk("rr_g0", grant_o, 4'b0001);
        chk("rr_adr0", s_adr_o, 32'h10);
        s_ack_i = 1'b1;
        #1 chk("rr_ack0", m_ack_o, 4'b0001);
        step();
        s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        step();
        chk("rr_idle0", {grant_o, s_cyc_o}, 5'b00000);
        step();
        chk("rr_g2", grant_o, 4'b0100);
        chk("rr_adr2", s_adr_o, 32'h20);
        s_rty_i = 1'b1;
        #1 chk("rr_rty2", {m_rty_o, m_ack_o}, 8'b0100_0000);
        step();
        s_rty_i = 1'b0;
        set_m(2, 0, 0, 0, 0, 0);
        step();
        chk("rr_idle2", {grant_o, s_cyc_o}, 5'b00000);
        step();
        chk("rr_g3", grant_o, 4'b1000);
        chk("rr_adr3", s_adr_o, 32'h30);
        s_ack_i = 1'b1;
        #1 chk("rr_ack3", m_ack_o, 4'b1000);
        step();
        s_ack_i = 1'b0;
        set_m(3, 0, 0, 0, 0, 0);
        step();
        chk("rr_idle3", {grant_o, s_cyc_o}, 5'b00000);

        // Locked CAS sequence from master 0 while master 1 waits
        do_reset();
        set_m(0, 1, 1, 0, 32'h200, 0);
        set_m(1, 1, 1, 0, 32'h300, 0);
        step();
        chk("cas_g0", grant_o, 4'b0001);
        chk("cas_rd", {s_adr_o, s_we_o}, {32'h200, 1'b0});
        s_ack_i = 1'b1;
        s_dat_i = 32'h1234;
        #1 chk("cas_rd_ack", m_ack_o, 4'b0001);
        step();
        s_ack_i = 1'b0;
        set_m(0, 1, 0, 0, 32'h200, 0);
        #1 chk("cas_gap", {s_cyc_o, s_stb_o}, 2'b10);
        step();
        chk("cas_hold", grant_o, 4'b0001);
        set_m(0, 1, 1, 1, 32'h200, 32'h55);
        #1 chk("cas_wr", {s_adr_o, s_dat_o, s_we_o}, {32'h200, 32'h55, 1'b1});
        s_ack_i = 1'b1;
        #1 chk("cas_wr_ack", m_ack_o, 4'b0001);
        step();
        s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        #1 chk("cas_drop", {grant_o, s_cyc_o}, 5'b00010);
        step();
        chk("cas_idle", grant_o, 4'b0000);
        step();
        chk("cas_g1", grant_o, 4'b0010);
        chk("cas_adr1", s_adr_o, 32'h300);
        set_m(1, 0, 0, 0, 0, 0);
        step();
        step();

        // Watchdog fires on the 8th stalled cycle, then a retry completes
        set_m(2, 1, 1, 0, 32'h400, 0);
        step();
        chk("wd_g2", grant_o, 4'b0100);
        for (int i = 2; i <= 7; i++) step();
        chk("wd_pre", {m_err_o, s_stb_o}, 5'b0000_1);
        step();
        chk("wd_err", m_err_o, 4'b0100);
        chk("wd_stb", {s_cyc_o, s_stb_o}, 2'b10);
        step();
        chk("wd_clear", {m_err_o, s_stb_o}, 5'b0000_1);
        s_ack_i = 1'b1;
        #1 chk("wd_retry_ack", {m_ack_o, m_err_o}, 8'b0100_0000);
        step();
        s_ack_i = 1'b0;
        set_m(2, 0, 0, 0, 0, 0);
        step();

        // Slave ack on the watchdog terminal cycle wins
        set_m(3, 1, 1, 0, 32'h500, 0);
        step();
        chk("wdack_g3", grant_o, 4'b1000);
        for (int i = 2; i <= 7; i++) step();
        step();
        s_ack_i = 1'b1;
        #1 chk("wdack_resp", {m_ack_o, m_err_o, s_stb_o}, 9'b1000_0000_1);
        step();
        s_ack_i = 1'b0;
        set_m(3, 0, 0, 0, 0, 0);
        step();

        // Asynchronous reset mid-GRANTED
        set_m(2, 1, 1, 0, 32'h600, 0);
        step();
        chk("ar_g2", grant_o, 4'b0100);
        s_ack_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1 chk("ar_grant", grant_o, 4'b0000);
        chk("ar_cyc", {s_cyc_o, s_stb_o}, 2'b00);
        chk("ar_ack", m_ack_o, 4'b0000);
        s_ack_i = 1'b0;
        set_m(2, 0, 0, 0, 0, 0);
        set_m(1, 1, 1, 0, 32'h700, 0);
        set_m(3, 1, 1, 0, 32'h800, 0);
        step();
        chk("ar_held", grant_o, 4'b0000);
        #3 rst_ni = 1'b1;
        step();
        chk("ar_regrant", grant_o, 4'b0010);
        chk("ar_adr", s_adr_o, 32'h700);
        set_m(1, 0, 0, 0, 0, 0);
        set_m(3, 0, 0, 0, 0, 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_bus_lock_arbiter.md
Name: wb_bus_lock_arbiter

Overview:
- Round-robin Wishbone arbiter placed directly downstream of the per-core CAS units.
- Merges MASTERS core-side buses onto one shared slave bus.
- Once a master is granted, it keeps the bus for as long as its cyc stays high. A CAS read/compare/write sequence, issued as one cyc, is therefore atomic against the other cores.
- Includes a stall watchdog that terminates a hung slave access with an error.

Parameters:
- MASTERS, 4, number of master ports (2..8).
- TIMEOUT, 255, cycles of stb without ack/err/rty before the arbiter returns err to the master (1..65535).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- m_adr_i  in  MASTERS*32  master addresses, master k at bits [32k+31:32k].
- m_dat_i  in  MASTERS*32  master write data.
- m_sel_i  in  MASTERS*4  byte selects.
- m_bte_i  in  MASTERS*2  burst type.
- m_cti_i  in  MASTERS*3  cycle type.
- m_we_i  in  MASTERS  write enables.
- m_cyc_i  in  MASTERS  cycle, also the bus request.
- m_stb_i  in  MASTERS  strobes.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o  out  MASTERS  per-master ack.
- m_err_o  out  MASTERS  per-master err.
- m_rty_o  out  MASTERS  per-master retry.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_bte_o  out  2  slave burst type.
- s_cti_o  out  3  slave cycle type.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_rty_i  in  1  slave retry.
- grant_o  out  MASTERS  one-hot registered grant, all zero when idle.

Behaviour:
- Reset, asynchronous, rst_ni low:
  - State IDLE; grant_o=0; last-grant pointer=MASTERS-1, so master 0 has highest priority first; watchdog count=0.
  - All s_* control outputs 0, m_ack/err/rty_o 0.
  - Reset mid-transaction drops s_cyc_o/s_stb_o immediately; no response reaches any master.
- State IDLE:
  - s_cyc_o=s_stb_o=0; s_adr/dat/sel/bte/cti/we_o=0.
  - If any m_cyc_i is high, select the first requester searching upward from last_grant+1, with modulo MASTERS wrap.
  - Register the selection into grant_o and last_grant, then go to GRANTED. This costs 1 cycle of arbitration latency.
  - A request that drops before the grant takes effect is still granted, then released the next cycle.
- State GRANTED, master g:
  - All s_* outputs combinationally follow master g's signals, except s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g].
  - s_ack/err/rty_i are routed combinationally to index g only; other masters see 0.
  - m_dat_o = s_dat_i at all times.
  - Requests from other masters are ignored.
  - When m_cyc_i[g] falls, s_cyc_o falls the same cycle (combinational). The next edge returns the FSM to IDLE and clears grant_o.
  - The earliest new grant is one cycle after that, so there is a minimum 1 idle cycle between owners.
- Watchdog:
  - Counts cycles in GRANTED with s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0.
  - Clears on any slave response, on stb low, and on leaving GRANTED.
  - When the count equals TIMEOUT-1 with still no response, m_err_o[g] is asserted for exactly that cycle and the count clears.
  - On a watchdog cycle s_stb_o is forced 0 while s_cyc_o stays with the master.
  - A slave response in the same cycle the watchdog would fire takes precedence: the slave response is forwarded, no err is generated.
  - Counter width is 16 bits; it must not wrap before TIMEOUT.
- Fairness: a master that has just released has lowest priority in the next arbitration. Any continuously requesting master is granted within MASTERS-1 other grants.
- No combinational path from m_cyc_i to grant_o; grant_o is a flop output.

Test Plan:
- Reset, then master 1 asserts cyc+stb, read at 0x0000_0100 -> grant_o=0010 one cycle later; s_adr_o=0x100. Slave acks with dat 0xDEADBEEF -> m_ack_o=0010, m_dat_o=0xDEADBEEF.
- Masters 0, 2 and 3 request simultaneously after reset, each releasing after one ack -> grant sequence 0, 2, 3. Each grant is separated by at least 1 idle cycle with s_cyc_o=0.
- Master 0 holds cyc across a read, then a write (CAS pattern) while master 1 requests -> master 1 gets no grant until master 0's cyc falls. Slave sees both accesses from master 0 with no interleaving.
- TIMEOUT=8, slave never responds -> m_err_o[g]=1 for one cycle on the 8th stalled cycle, with s_stb_o=0 that cycle. The master retries and the slave acks -> normal ack.
- Slave ack coincides with the watchdog terminal cycle -> only m_ack_o is asserted, m_err_o stays 0.
- rst_ni pulsed low mid-GRANTED -> s_cyc_o, grant_o and m_ack_o go 0 asynchronously. After reset release the next arbitration starts from master 0.
